// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory; each access takes IDLE->ACCESS->RESP.
// Optional address bounds checking is enabled by defining DMEM_ARB_BOUNDS_CHECK_EN.
module dmem_arbiter #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam logic BOUNDS_CHECK = 1'b1;
`else
  localparam logic BOUNDS_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_grant;
  logic        any_req;
  logic        win_port;
  logic        win_we;
  logic        win_oob;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        cap_port;
  logic        cap_we;
  logic        cap_oob;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] resp_data;

  // Round-robin winner selection and selection of the winner's request fields.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      win_port = ~last_grant;
    end else begin
      win_port = req1;
    end
    if (win_port) begin
      win_we    = we1;
      win_addr  = addr1;
      win_wdata = wdata1;
    end else begin
      win_we    = we0;
      win_addr  = addr0;
      win_wdata = wdata0;
    end
    win_oob = BOUNDS_CHECK & (win_addr >= 32'(DEPTH));
  end

  // Next-state logic and grant pulses; grants only come out of IDLE.
  always_comb begin
    state_next = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !rst) begin
          state_next = ACCESS;
          gnt0       = ~win_port;
          gnt1       = win_port;
        end else begin
          state_next = IDLE;
        end
      end
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture of the granted request; later changes on the request lines are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      cap_port   <= 1'b0;
      cap_we     <= 1'b0;
      cap_oob    <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
    end else if (state == IDLE && any_req) begin
      last_grant <= win_port;
      cap_port   <= win_port;
      cap_we     <= win_we;
      cap_oob    <= win_oob;
      cap_addr   <= win_addr;
      cap_wdata  <= win_wdata;
    end
  end

  // Memory strobes are gated with rst so a reset during ACCESS never writes.
  always_comb begin
    if (state == ACCESS) begin
      mem_write = cap_we & ~cap_oob & ~rst;
      mem_read  = ~cap_we & ~cap_oob & ~rst;
      mem_addr  = cap_addr;
      mem_wdata = cap_wdata;
    end else begin
      mem_write = 1'b0;
      mem_read  = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
    end
    if (cap_we || cap_oob) begin
      resp_data = 32'd0;
    end else begin
      resp_data = mem_rdata;
    end
    busy = (state != IDLE);
  end

  // Response registers: loaded at the closing edge of ACCESS, so they are valid exactly during RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= 32'd0;
      rdata1 <= 32'd0;
      err0   <= 1'b0;
      err1   <= 1'b0;
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= 32'd0;
      rdata1 <= 32'd0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      if (state == ACCESS) begin
        if (cap_port) begin
          done1  <= 1'b1;
          rdata1 <= resp_data;
          err1   <= cap_oob;
        end else begin
          done0  <= 1'b1;
          rdata0 <= resp_data;
          err0   <= cap_oob;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, multi-cycle corner sequences and randomized traffic.
module tb_dmem_arbiter;
  localparam int DEPTH = 64;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_clear;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        last_port;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_mem_en;
  } vec_t;
  vec_t tbl[11];
  logic [31:0] pre[3];

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Attached data memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (mem_write && mem_addr < 32'(DEPTH)) begin
      mem[mem_addr[5:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = (mem_read && mem_addr < 32'(DEPTH)) ? mem[mem_addr[5:0]] : 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0;
  endtask

  function automatic logic pick(input logic r0, input logic r1);
    if (r0 && r1) return ~last_port;
    return r1;
  endfunction

  // One complete transaction starting in an IDLE cycle; inputs are scrambled after the grant.
  task automatic run_txn(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                         input logic win, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_mem_en, input string tag);
    logic        w_we;
    logic [31:0] w_addr, w_data;
    w_we   = win ? w1 : w0;
    w_addr = win ? a1 : a0;
    w_data = win ? d1 : d0;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    check({tag, " gnt"}, 32'({gnt1, gnt0}), win ? 32'd2 : 32'd1);
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    tick();
    req0 = 1'b0; req1 = 1'b0; we0 = ~w0; we1 = ~w1;
    addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
    @(negedge clk);
    check({tag, " strobes"}, 32'({mem_write, mem_read}), exp_mem_en ? (w_we ? 32'd2 : 32'd1) : 32'd0);
    if (exp_mem_en) check({tag, " mem_addr"}, mem_addr, w_addr);
    if (exp_mem_en && w_we) check({tag, " mem_wdata"}, mem_wdata, w_data);
    check({tag, " gnt in access"}, 32'({gnt1, gnt0, busy}), 32'd1);
    tick();
    @(negedge clk);
    check({tag, " done"}, 32'({done1, done0}), win ? 32'd2 : 32'd1);
    check({tag, " rdata"}, win ? rdata1 : rdata0, exp_rdata);
    check({tag, " err"}, 32'(win ? err1 : err0), 32'(exp_err));
    check({tag, " other port"}, (win ? rdata0 : rdata1) | 32'(win ? err0 : err1), 32'd0);
    check({tag, " mem idle in resp"}, mem_addr | mem_wdata | 32'({mem_write, mem_read}), 32'd0);
    tick();
    drive_idle();
    last_port = win;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dual, nd;
    int          gcyc[$];
    logic        gport[$];
    logic [1:0]  r;
    logic        w, win;
    logic [31:0] a, d, e;

    tbl[0]  = '{1'b0, 1'b1, 32'd5,  32'hDEADBEEF, 32'd0,        1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 32'd5,  32'd0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 32'd0,  32'h00000011, 32'd0,        1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'd1,  32'h00000022, 32'd0,        1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'd2,  32'h00000033, 32'd0,        1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'd5,  32'd0,        32'hDEADBEEF, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'd63, 32'hA5A5A5A5, 32'd0,        1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'd63, 32'd0,        32'hA5A5A5A5, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 32'd7,  32'hCAFE0007, 32'd0,        1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 32'd64, 32'h0BAD0BAD, 32'd0,        CHK,  ~CHK};
    tbl[10] = '{1'b0, 1'b0, 32'd64, 32'd0,        32'd0,        CHK,  ~CHK};
    pre[0] = 32'h11; pre[1] = 32'h22; pre[2] = 32'h33;

    // Reset with both requests already asserted; nothing may be granted while rst is high.
    drive_idle();
    rst = 1'b1; mem_clear = 1'b1;
    tick();
    mem_clear = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'd0; addr1 = 32'd1;
    @(negedge clk);
    check("reset outputs", 32'({gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write, busy}), 32'd0);
    check("reset data", rdata0 | rdata1 | mem_addr | mem_wdata, 32'd0);
    tick();
    rst = 1'b0;
    last_port = 1'b1;

    // Contention from reset: grants alternate 0,1,0,1 three cycles apart.
    dual = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) dual++;
      if (gnt0 || gnt1) begin
        gcyc.push_back(c);
        gport.push_back(gnt1);
      end
      tick();
    end
    drive_idle();
    check("contention grant count", 32'(gcyc.size()), 32'd4);
    for (int k = 0; k < 4 && k < gcyc.size(); k++) begin
      check($sformatf("contention port %0d", k), 32'(gport[k]), 32'(k % 2));
      check($sformatf("contention cycle %0d", k), 32'(gcyc[k]), 32'(3 * k));
    end
    check("contention dual grant", 32'(dual), 32'd0);
    last_port = 1'b1;
    @(negedge clk);
    check("idle after contention", 32'({gnt0, gnt1, done0, done1, mem_read, mem_write, busy}), 32'd0);
    tick();

    // Directed single-port transactions.
    for (int i = 0; i < 11; i++) begin
      run_txn(~tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
              tbl[i].port, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_mem_en,
              $sformatf("vec%0d", i));
    end

    // Port 1 holds req through three back-to-back reads of 0..2.
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("b2b gnt %0d", k), 32'({gnt1, gnt0}), 32'd2);
      tick();
      addr1 = 32'(k + 1);
      @(negedge clk);
      check($sformatf("b2b no regrant %0d", k), 32'({gnt1, gnt0}), 32'd0);
      tick();
      @(negedge clk);
      check($sformatf("b2b done %0d", k), 32'({done1, done0, gnt1, gnt0}), 32'd8);
      check($sformatf("b2b rdata1 %0d", k), rdata1, pre[k]);
      check($sformatf("b2b port0 quiet %0d", k), rdata0 | 32'(err0), 32'd0);
      tick();
    end
    drive_idle();
    last_port = 1'b1;

    // Reset in the ACCESS cycle of a write: no write, no done, old data survives.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h00001234;
    @(negedge clk);
    check("rst-access gnt", 32'({gnt1, gnt0}), 32'd1);
    tick();
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst-access mem_write", 32'(mem_write), 32'd0);
    tick();
    rst = 1'b0;
    last_port = 1'b1;
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done0 || done1 || busy) nd++;
      tick();
    end
    check("rst-access no done", 32'(nd), 32'd0);
    run_txn(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'hCAFE0007, 1'b0, 1'b1, "rst-access readback");

    // Randomized traffic against a word-array reference model.
    mem_clear = 1'b1;
    tick();
    mem_clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;
    for (int n = 0; n < 60; n++) begin
      logic        w0r, w1r;
      logic [31:0] a0r, a1r, d0r, d1r;
      r   = 2'($urandom_range(1, 3));
      w0r = 1'($urandom_range(0, 1)); w1r = 1'($urandom_range(0, 1));
      a0r = 32'($urandom_range(0, 7)); a1r = 32'($urandom_range(0, 7));
      d0r = $urandom; d1r = $urandom;
      win = pick(r[0], r[1]);
      w = win ? w1r : w0r;
      a = win ? a1r : a0r;
      d = win ? d1r : d0r;
      e = w ? 32'd0 : ref_mem[a];
      run_txn(r[0], w0r, a0r, d0r, r[1], w1r, a1r, d1r, win, e, 1'b0, 1'b1, $sformatf("rand%0d", n));
      if (w) ref_mem[a] = d;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  access request from port 0 (core load/store) / port 1 (debug/loader).
REQ-005 we0 / we1  input  1  1 = write, 0 = read, valid while reqN high.
REQ-006 addr0 / addr1  input  32  word address, valid while reqN high.
REQ-007 wdata0 / wdata1  input  32  write data, valid while reqN high and weN high.
REQ-008 gnt0 / gnt1  output  1  one-cycle pulse: request accepted and captured.
REQ-009 done0 / done1  output  1  one-cycle pulse: access complete, rdataN/errN valid.
REQ-010 rdata0 / rdata1  output  32  read data, valid with doneN, 0 for writes.
REQ-011 err0 / err1  output  1  access rejected (bounds check only), valid with doneN.
REQ-012 mem_read / mem_write  output  1  memory read enable / write enable.
REQ-013 mem_addr / mem_wdata  output  32  memory address / write data.
REQ-014 mem_rdata  input  32  memory read data, combinational from mem_addr when mem_read high.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, ACCESS, RESP; every transaction takes exactly IDLE->ACCESS->RESP->IDLE, three cycles.
REQ-017 IDLE: if any reqN high, pulse gntN for the winner, capture port id, we, addr and wdata into registers, go to ACCESS; else stay.
REQ-018 Arbitration round-robin: single requester always wins; both high -> port not granted last wins; last-grant pointer resets to port 1, so port 0 wins the first contention.
REQ-019 ACCESS: drive mem_addr/mem_wdata from captured values; mem_write = captured we, mem_read = !captured we, each high for exactly this one cycle; capture mem_rdata at the closing edge for reads, 0 for writes.
REQ-020 RESP: pulse doneN for the captured port with rdataN/errN; return to IDLE; no arbitration in RESP.
REQ-021 mem_read and mem_write SHALL be 0 outside ACCESS; mem_addr/mem_wdata SHALL be 0 outside ACCESS.
REQ-022 gnt and done are never asserted for both ports in the same cycle; the non-selected port's done/rdata/err stay 0.
REQ-023 req deasserted before gnt = withdrawn, no access; after gnt, req/we/addr/wdata changes do not affect the transaction.
REQ-024 A req held high through RESP is re-arbitrated in the following IDLE cycle; back-to-back throughput is one access per three cycles.
REQ-025 Addresses are used as word indices unchanged; no byte-lane logic.

Reset
REQ-026 rst high at a clock edge: state -> IDLE, last-grant pointer -> port 1, captured registers -> 0, from any state.
REQ-027 All outputs 0 while in IDLE after reset; mem_write SHALL be 0 in any cycle where rst is high, so a reset during ACCESS performs no write.
REQ-028 A transaction interrupted by reset produces no done pulse.

Configuration
REQ-029 Macro DMEM_ARB_BOUNDS_CHECK_EN defined: captured addr >= DEPTH -> ACCESS keeps mem_read/mem_write at 0, RESP pulses done with err=1 and rdata=0; timing unchanged.
REQ-030 Macro undefined: no check, address forwarded unchanged, err0/err1 tied 0.

Verification
REQ-031 Port 0 write addr 5 data 0xDEADBEEF, then read addr 5 -> gnt0 at cycle 0, mem_write high cycle 1, done0 cycle 2; read returns rdata0=0xDEADBEEF, err0=0.
REQ-032 req0 and req1 both held high from reset, four transactions -> grant order 0,1,0,1, gnt pulses 3 cycles apart.
REQ-033 Port 1 alone, 3 back-to-back reads of addr 0..2 preloaded 0x11,0x22,0x33 -> done1 every 3rd cycle with those values, port 0 outputs stay 0.
REQ-034 rst asserted in ACCESS of a write to addr 7 data 0x1234 -> mem_write 0 that cycle, no done, next read of addr 7 returns prior value.
REQ-035 With DMEM_ARB_BOUNDS_CHECK_EN, port 0 write addr 64 -> mem_write never high, done0 with err0=1, rdata0=0; without macro err0=0 and mem_addr=64 in ACCESS.
